// File: rtl/axis_pkt_rx.sv
// axis_pkt_rx: store-and-forward AXI4-Stream packet receiver.
// Beats are buffered in a circular word store and become readable only once
// the tlast beat of their packet has been accepted. Packets that do not fit
// (buffer full or packet limit reached) are dropped whole.
// Optional statistics outputs (drop_count, rx_count) are enabled by defining
// PIRADIP_AXIS_RX_STATS_EN.
module axis_pkt_rx #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 64,
    parameter int MAX_PKTS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic [WIDTH-1:0]          s_tdata,
    input  logic [WIDTH/8-1:0]        s_tkeep,
    input  logic                      s_tlast,
    input  logic                      rd_en,
    output logic                      rd_valid,
    output logic [WIDTH-1:0]          rd_data,
    output logic [WIDTH/8-1:0]        rd_keep,
    output logic                      rd_last,
    output logic [$clog2(MAX_PKTS):0] pkt_count
`ifdef PIRADIP_AXIS_RX_STATS_EN
    ,
    output logic [15:0]               drop_count,
    output logic [15:0]               rx_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(MAX_PKTS) + 1;

    typedef enum logic {ACCEPT, DROP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr, commit_ptr, rd_ptr;
    logic            beat, full, limit;
    logic            do_write, do_commit, do_drop;
    logic            pop, pop_last;

    logic [WIDTH-1:0]   mem_data [DEPTH];
    logic [WIDTH/8-1:0] mem_keep [DEPTH];
    logic               mem_last [DEPTH];

    assign s_tready = ~reset;
    assign beat     = s_tvalid && s_tready;
    assign full     = (wr_ptr + AW'(1)) == rd_ptr;
    assign limit    = pkt_count == PW'(MAX_PKTS);

    assign rd_valid = rd_ptr != commit_ptr;
    assign rd_data  = mem_data[rd_ptr];
    assign rd_keep  = mem_keep[rd_ptr];
    assign rd_last  = mem_last[rd_ptr];
    assign pop      = rd_en && rd_valid;
    assign pop_last = pop && mem_last[rd_ptr];

    // Write FSM next state and per-beat store/commit/drop decisions
    always_comb begin
        state_d   = state_q;
        do_write  = 1'b0;
        do_commit = 1'b0;
        do_drop   = 1'b0;
        if (beat) begin
            case (state_q)
                ACCEPT: begin
                    if (full || limit) begin
                        do_drop = 1'b1;
                        if (!s_tlast) state_d = DROP;
                    end else begin
                        do_write  = 1'b1;
                        do_commit = s_tlast;
                    end
                end
                DROP: begin
                    if (s_tlast) state_d = ACCEPT;
                end
                default: state_d = ACCEPT;
            endcase
        end
    end

    // State, pointers and committed packet count
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACCEPT;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pkt_count  <= '0;
        end else begin
            state_q <= state_d;
            if (do_write)  wr_ptr     <= wr_ptr + AW'(1);
            if (do_commit) commit_ptr <= wr_ptr + AW'(1);
            if (do_drop)   wr_ptr     <= commit_ptr;
            if (pop)       rd_ptr     <= rd_ptr + AW'(1);
            // A commit and a last-word pop in the same cycle cancel out
            if (do_commit && !pop_last)
                pkt_count <= pkt_count + PW'(1);
            else if (!do_commit && pop_last)
                pkt_count <= pkt_count - PW'(1);
        end
    end

    // Word storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_data[wr_ptr] <= s_tdata;
            mem_keep[wr_ptr] <= s_tkeep;
            mem_last[wr_ptr] <= s_tlast;
        end
    end

`ifdef PIRADIP_AXIS_RX_STATS_EN
    // Saturating drop counter and wrapping receive counter
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
            rx_count   <= '0;
        end else begin
            if (do_drop && drop_count != '1) drop_count <= drop_count + 16'd1;
            if (do_commit)                   rx_count   <= rx_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_pkt_rx.sv
// tb_axis_pkt_rx: bench for axis_pkt_rx (DEPTH=8, MAX_PKTS=2).
// Vector table plus directed sequences plus randomized traffic against a
// queue-based packet model.
module tb_axis_pkt_rx;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 8;
    localparam int MAX_PKTS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic        rd_en = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [3:0]  rd_keep;
    logic        rd_last;
    logic [1:0]  pkt_count;
`ifdef PIRADIP_AXIS_RX_STATS_EN
    logic [15:0] drop_count;
    logic [15:0] rx_count;
`endif

    int checks   = 0;
    int failures = 0;

    axis_pkt_rx #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .MAX_PKTS (MAX_PKTS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .rd_en     (rd_en),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_keep   (rd_keep),
        .rd_last   (rd_last),
        .pkt_count (pkt_count)
`ifdef PIRADIP_AXIS_RX_STATS_EN
        ,
        .drop_count(drop_count),
        .rx_count  (rx_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: committed words awaiting read, and the packet in flight
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    word_t    mq[$];
    word_t    pq[$];
    bit       m_dropping = 1'b0;
    int       m_drops = 0;
    int       m_rx = 0;

    function automatic int m_pkts();
        int n = 0;
        foreach (mq[i]) if (mq[i].l) n++;
        return n;
    endfunction

    task automatic model_step(input logic v, input logic [31:0] d, input logic [3:0] k,
                              input logic l, input logic r, input logic rst);
        int    occ;
        int    pk;
        bit    popping;
        word_t w;
        if (rst) begin
            mq.delete();
            pq.delete();
            m_dropping = 1'b0;
            m_drops    = 0;
            m_rx       = 0;
            return;
        end
        occ     = mq.size() + pq.size();
        pk      = m_pkts();
        popping = r && (mq.size() > 0);
        w       = '{d: d, k: k, l: l};
        if (v) begin
            if (m_dropping) begin
                if (l) m_dropping = 1'b0;
            end else if (occ == DEPTH - 1 || pk == MAX_PKTS) begin
                pq.delete();
                m_dropping = !l;
                if (m_drops < 65535) m_drops++;
            end else begin
                pq.push_back(w);
                if (l) begin
                    foreach (pq[i]) mq.push_back(pq[i]);
                    pq.delete();
                    m_rx = (m_rx + 1) % 65536;
                end
            end
        end
        if (popping) void'(mq.pop_front());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance DUT and model together, settle past the edge
    task automatic tick(input logic v, input logic [31:0] d, input logic [3:0] k,
                        input logic l, input logic r, input logic rst);
        s_tvalid = v;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        rd_en    = r;
        reset    = rst;
        @(posedge clk);
        model_step(v, d, k, l, r, rst);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        tick(1'b1, d, 4'hF, l, 1'b0, 1'b0);
    endtask

    task automatic idle();
        tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
    endtask

    // Check the head word against constants, then pop it
    task automatic pop_expect(input string name, input logic [31:0] d, input logic l);
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk({name, "_data"}, rd_data, d);
        chk({name, "_last"}, 32'(rd_last), 32'(l));
        tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_ready"}, 32'(s_tready), 32'(!reset));
        chk({tag, "_valid"}, 32'(rd_valid), 32'(mq.size() > 0));
        chk({tag, "_count"}, 32'(pkt_count), 32'(m_pkts()));
        if (mq.size() > 0 && rd_valid) begin
            chk({tag, "_data"}, rd_data, mq[0].d);
            chk({tag, "_keep"}, 32'(rd_keep), 32'(mq[0].k));
            chk({tag, "_last"}, 32'(rd_last), 32'(mq[0].l));
        end
`ifdef PIRADIP_AXIS_RX_STATS_EN
        chk({tag, "_drops"}, 32'(drop_count), 32'(m_drops));
        chk({tag, "_rx"}, 32'(rx_count), 32'(m_rx));
`endif
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        r;
        logic        rst;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        int          ec;
        logic        erdy;
    } vec_t;

    function automatic vec_t mk(logic v, logic [31:0] d, logic l, logic r, logic rst,
                                logic ev, logic [31:0] ed, logic el, int ec, logic erdy);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.r = r; t.rst = rst;
        t.ev = ev; t.ed = ed; t.el = el; t.ec = ec; t.erdy = erdy;
        return t;
    endfunction

    vec_t tbl[11];

    initial begin
        // Single packet, empty pop, then commit coinciding with a last-word pop
        tbl[0]  = mk(0, 32'h0,  0, 0, 1,  0, 32'h0,  0, 0, 0);
        tbl[1]  = mk(1, 32'hA1, 0, 0, 0,  0, 32'h0,  0, 0, 1);
        tbl[2]  = mk(1, 32'hA2, 0, 0, 0,  0, 32'h0,  0, 0, 1);
        tbl[3]  = mk(1, 32'hA3, 1, 0, 0,  1, 32'hA1, 0, 1, 1);
        tbl[4]  = mk(0, 32'h0,  0, 1, 0,  1, 32'hA2, 0, 1, 1);
        tbl[5]  = mk(0, 32'h0,  0, 1, 0,  1, 32'hA3, 1, 1, 1);
        tbl[6]  = mk(0, 32'h0,  0, 1, 0,  0, 32'h0,  0, 0, 1);
        tbl[7]  = mk(0, 32'h0,  0, 1, 0,  0, 32'h0,  0, 0, 1);
        tbl[8]  = mk(1, 32'hB1, 1, 0, 0,  1, 32'hB1, 1, 1, 1);
        tbl[9]  = mk(1, 32'hC1, 1, 1, 0,  1, 32'hC1, 1, 1, 1);
        tbl[10] = mk(0, 32'h0,  0, 1, 0,  0, 32'h0,  0, 0, 1);

        for (int i = 0; i < 11; i++) begin
            tick(tbl[i].v, tbl[i].d, 4'hF, tbl[i].l, tbl[i].r, tbl[i].rst);
            chk($sformatf("row%0d_valid", i), 32'(rd_valid), 32'(tbl[i].ev));
            chk($sformatf("row%0d_count", i), 32'(pkt_count), 32'(tbl[i].ec));
            chk($sformatf("row%0d_ready", i), 32'(s_tready), 32'(tbl[i].erdy));
            if (tbl[i].ev) begin
                chk($sformatf("row%0d_data", i), rd_data, tbl[i].ed);
                chk($sformatf("row%0d_last", i), 32'(rd_last), 32'(tbl[i].el));
            end
            if (tbl[i].rst) begin
                reset = 1'b0;
                #1;
            end
        end

        // Visibility: 5-beat packet with a gap after beat 2
        send(32'h51, 0); chk("vis_b1", 32'(rd_valid), 32'd0);
        send(32'h52, 0); chk("vis_b2", 32'(rd_valid), 32'd0);
        idle();          chk("vis_gap", 32'(rd_valid), 32'd0);
        send(32'h53, 0); chk("vis_b3", 32'(rd_valid), 32'd0);
        send(32'h54, 0); chk("vis_b4", 32'(rd_valid), 32'd0);
        send(32'h55, 1); chk("vis_b5", 32'(rd_valid), 32'd1);
        chk("vis_count", 32'(pkt_count), 32'd1);
        for (int i = 0; i < 5; i++)
            pop_expect($sformatf("vis_pop%0d", i), 32'h51 + 32'(i), 1'(i == 4));
        chk("vis_empty", 32'(rd_valid), 32'd0);

        // Overflow: 4-beat packet fits, following 6-beat packet does not
        do_reset();
        for (int i = 0; i < 4; i++) send(32'hD0 + 32'(i), 1'(i == 3));
        for (int i = 0; i < 6; i++) send(32'hE0 + 32'(i), 1'(i == 5));
        chk("ovf_count", 32'(pkt_count), 32'd1);
`ifdef PIRADIP_AXIS_RX_STATS_EN
        chk("ovf_drops", 32'(drop_count), 32'd1);
        chk("ovf_rx", 32'(rx_count), 32'd1);
`endif
        for (int i = 0; i < 4; i++)
            pop_expect($sformatf("ovf_pop%0d", i), 32'hD0 + 32'(i), 1'(i == 3));
        chk("ovf_empty", 32'(rd_valid), 32'd0);
        chk("ovf_count0", 32'(pkt_count), 32'd0);

        // Packet limit: third 1-beat packet dropped, accepted again after pops
        do_reset();
        send(32'hF0, 1);
        send(32'hF1, 1);
        send(32'hF2, 1);
        chk("lim_count", 32'(pkt_count), 32'd2);
`ifdef PIRADIP_AXIS_RX_STATS_EN
        chk("lim_drops", 32'(drop_count), 32'd1);
`endif
        pop_expect("lim_pop0", 32'hF0, 1);
        pop_expect("lim_pop1", 32'hF1, 1);
        chk("lim_empty", 32'(rd_valid), 32'd0);
        send(32'hF3, 1);
        chk("lim_count_after", 32'(pkt_count), 32'd1);
        pop_expect("lim_pop2", 32'hF3, 1);

        // Reset mid-packet with committed data present
        send(32'h71, 1);
        send(32'h81, 0);
        send(32'h82, 0);
        do_reset();
        chk("rst_count", 32'(pkt_count), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 4; i++) send(32'h90 + 32'(i), 1'(i == 3));
        chk("rst_count_after", 32'(pkt_count), 32'd1);
        for (int i = 0; i < 4; i++)
            pop_expect($sformatf("rst_pop%0d", i), 32'h90 + 32'(i), 1'(i == 3));
        chk("rst_empty", 32'(rd_valid), 32'd0);

        // Randomized traffic against the model
        do_reset();
        cmp_model("rnd_init");
        for (int i = 0; i < 3000; i++) begin
            logic        v, l, r, rst;
            logic [31:0] d;
            logic [3:0]  k;
            v   = ($urandom_range(0, 9) < 7);
            d   = $urandom;
            k   = 4'($urandom);
            l   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 299) == 0);
            tick(v, d, k, l, r, rst);
            cmp_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
